// File: rtl/vga_mem_arbiter.sv
// Frame-buffer RAM arbiter: VGA scan-out owns the single-port RAM during active video,
// two pixel writers share it round-robin during blanking via a req/gnt handshake.
module vga_mem_arbiter #(
    parameter int FB_W        = 160,
    parameter int FB_H        = 120,
    parameter int SCALE_SHIFT = 2,
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 16
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              active_video,
    input  logic              w0_req,
    input  logic [ADDR_W-1:0] w0_addr,
    input  logic [DATA_W-1:0] w0_data,
    output logic              w0_gnt,
    input  logic              w1_req,
    input  logic [ADDR_W-1:0] w1_addr,
    input  logic [DATA_W-1:0] w1_data,
    output logic              w1_gnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [4:0]        red,
    output logic [5:0]        green,
    output logic [4:0]        blue,
    output logic              err_oob
);

    localparam logic [1:0] BLANK_IDLE  = 2'd0;
    localparam logic [1:0] BLANK_WRITE = 2'd1;
    localparam logic [1:0] SCAN        = 2'd2;

    localparam int unsigned FB_SIZE = FB_W * FB_H;
    localparam int          MUL_W   = 2 * ADDR_W;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic              rr_ptr;      // 0: w0 has priority on a tie
    logic [ADDR_W-1:0] scan_addr;
    logic              win_sel;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic              win_oob;

    // Row-major buffer address; the wide intermediate keeps the product exact before truncation.
    assign scan_addr = ADDR_W'(MUL_W'(y >> SCALE_SHIFT) * MUL_W'(FB_W) + MUL_W'(x >> SCALE_SHIFT));

    // Scan-out always wins: active_video overrides any pending request at the same edge.
    always_comb begin
        if (active_video) begin
            state_next = SCAN;
        end else if (w0_req || w1_req) begin
            state_next = BLANK_WRITE;
        end else begin
            state_next = BLANK_IDLE;
        end
    end

    always_comb begin
        win_sel = 1'b0;
        if (w0_req && w1_req) begin
            win_sel = rr_ptr;
        end else if (w1_req) begin
            win_sel = 1'b1;
        end
        win_addr = win_sel ? w1_addr : w0_addr;
        win_data = win_sel ? w1_data : w0_data;
        win_oob  = 32'(win_addr) >= FB_SIZE;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state     <= BLANK_IDLE;
            rr_ptr    <= 1'b0;
            w0_gnt    <= 1'b0;
            w1_gnt    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            red       <= '0;
            green     <= '0;
            blue      <= '0;
            err_oob   <= 1'b0;
        end else begin
            state  <= state_next;
            w0_gnt <= 1'b0;
            w1_gnt <= 1'b0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            // state==SCAN marks that the address now on the RAM was a scan-out read.
            {red, green, blue} <= (state == SCAN) ? mem_rdata : '0;
            case (state_next)
                SCAN: begin
                    mem_en   <= 1'b1;
                    mem_addr <= scan_addr;
                end
                BLANK_WRITE: begin
                    w0_gnt    <= !win_sel;
                    w1_gnt    <= win_sel;
                    rr_ptr    <= !win_sel;
                    mem_addr  <= win_addr;
                    mem_wdata <= win_data;
                    if (win_oob) begin
                        err_oob <= 1'b1;
                    end else begin
                        mem_en <= 1'b1;
                        mem_we <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Self-checking bench for vga_mem_arbiter: directed steps then randomized traffic,
// compared each cycle against a behavioural model of the arbitration rules.
module tb_vga_mem_arbiter;

    localparam int FB_W = 160;
    localparam int FB_H = 120;

    logic        clk_in;
    logic        reset;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        active_video;
    logic        w0_req;
    logic [14:0] w0_addr;
    logic [15:0] w0_data;
    logic        w0_gnt;
    logic        w1_req;
    logic [14:0] w1_addr;
    logic [15:0] w1_data;
    logic        w1_gnt;
    logic        mem_en;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [4:0]  red;
    logic [5:0]  green;
    logic [4:0]  blue;
    logic        err_oob;

    vga_mem_arbiter dut (
        .clk_in(clk_in), .reset(reset), .x(x), .y(y), .active_video(active_video),
        .w0_req(w0_req), .w0_addr(w0_addr), .w0_data(w0_data), .w0_gnt(w0_gnt),
        .w1_req(w1_req), .w1_addr(w1_addr), .w1_data(w1_data), .w1_gnt(w1_gnt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .red(red), .green(green), .blue(blue), .err_oob(err_oob)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Frame-buffer RAM: read data follows the registered address, writes commit at the edge.
    logic [15:0] ram [0:32767];
    always_comb mem_rdata = ram[mem_addr];
    always @(posedge clk_in) if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;

    // Reference model state
    logic [15:0] shadow [0:32767];
    int          vectors;
    int          miscompares;
    int          last_win;
    logic        prev_av;
    logic [14:0] prev_addr;
    logic        pend_v;
    int          pend_a;
    logic [15:0] pend_d;
    logic        err_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        last_win = 1;
        prev_av  = 1'b0;
        pend_v   = 1'b0;
        err_m    = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, {w0_gnt, w1_gnt}, 0);
        check({tag, "_mem"}, {mem_en, mem_we, mem_addr, mem_wdata}, 0);
        check({tag, "_rgb"}, {red, green, blue}, 0);
        check({tag, "_err"}, err_oob, 0);
    endtask

    // One clock: predict from current inputs, advance, compare.
    task automatic step();
        logic        av_s;
        logic        e_en, e_we, e_g0, e_g1;
        logic [14:0] e_addr;
        logic [15:0] e_wd, e_rgb;
        int          win;
        int          a;
        av_s = active_video;
        if (pend_v) shadow[pend_a] = pend_d;
        pend_v = 1'b0;
        e_rgb  = prev_av ? shadow[prev_addr] : 16'h0;
        e_en = 1'b0; e_we = 1'b0; e_g0 = 1'b0; e_g1 = 1'b0;
        e_addr = '0; e_wd = '0;
        if (av_s) begin
            e_en   = 1'b1;
            e_addr = 15'((int'(y) / 4) * FB_W + int'(x) / 4);
        end else if (w0_req || w1_req) begin
            if (w0_req && w1_req) win = 1 - last_win;
            else                  win = w0_req ? 0 : 1;
            last_win = win;
            e_g0 = (win == 0);
            e_g1 = (win == 1);
            a    = (win == 0) ? int'(w0_addr) : int'(w1_addr);
            e_wd = (win == 0) ? w0_data : w1_data;
            if (a < FB_W * FB_H) begin
                e_en = 1'b1; e_we = 1'b1; e_addr = 15'(a);
                pend_v = 1'b1; pend_a = a; pend_d = e_wd;
            end else begin
                err_m = 1'b1;
            end
        end
        @(posedge clk_in);
        #1;
        check("w0_gnt", w0_gnt, e_g0);
        check("w1_gnt", w1_gnt, e_g1);
        check("mem_en", mem_en, e_en);
        check("mem_we", mem_we, e_we);
        if (e_en) check("mem_addr", mem_addr, e_addr);
        if (e_we) check("mem_wdata", mem_wdata, e_wd);
        check("rgb", {red, green, blue}, e_rgb);
        check("err_oob", err_oob, err_m);
        prev_av   = av_s;
        prev_addr = e_addr;
    endtask

    initial begin
        int av_left;
        vectors = 0;
        miscompares = 0;
        for (int i = 0; i < 32768; i++) begin
            ram[i]    <= 16'h0;
            shadow[i]  = 16'h0;
        end
        ram[161]    <= 16'hF800;
        shadow[161]  = 16'hF800;
        model_reset();

        // Reset held with both writers requesting
        reset = 1'b0; x = '0; y = '0; active_video = 1'b0;
        w0_req = 1'b1; w0_addr = 15'd100; w0_data = 16'hAAAA;
        w1_req = 1'b1; w1_addr = 15'd200; w1_data = 16'hBBBB;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_in); #1;
            check_all_zero("reset_hold");
        end
        reset = 1'b1;

        // Round-robin with both writers holding req: w0, w1, w0, w1
        step(); check("first_grant_w0", w0_gnt, 1);
        step(); check("rr_second_w1", w1_gnt, 1);
        step();
        step();
        w0_req = 1'b0; w1_req = 1'b0;
        step();

        // Scan-out of preloaded pixel at buffer address 161
        x = 10'd4; y = 10'd4; active_video = 1'b1;
        step(); check("scan_addr_161", mem_addr, 161);
        step(); check("scan_rgb_red", {red, green, blue}, {5'd31, 6'd0, 5'd0});
        active_video = 1'b0;
        step();
        step(); check("rgb_blank_zero", {red, green, blue}, 0);

        // w1 blocked during active video, served on the first blanking cycle
        x = 10'd0; y = 10'd0; active_video = 1'b1;
        w1_req = 1'b1; w1_addr = 15'd500; w1_data = 16'h1234;
        for (int i = 0; i < 10; i++) step();
        active_video = 1'b0;
        step(); check("blocked_then_w1_gnt", w1_gnt, 1);
        w1_req = 1'b0;
        step();
        x = 10'd80; y = 10'd12; active_video = 1'b1;
        step(); step(); check("written_pixel_readback", {red, green, blue}, 16'h1234);
        active_video = 1'b0;

        // Out-of-range write: granted, no RAM access, sticky error
        w0_req = 1'b1; w0_addr = 15'd19200; w0_data = 16'hDEAD;
        step(); check("oob_gnt", w0_gnt, 1); check("oob_no_we", mem_we, 0);
        w0_req = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("oob_sticky", err_oob, 1);

        // Cancelled request: raised during video, dropped before blanking
        active_video = 1'b1; x = 10'd560; y = 10'd4;
        w0_req = 1'b1; w0_addr = 15'd300; w0_data = 16'h5555;
        step(); step();
        w0_req = 1'b0;
        step();
        active_video = 1'b0;
        step(); check("cancel_no_gnt", w0_gnt, 0);
        active_video = 1'b1;
        step(); step(); check("cancel_no_write", {red, green, blue}, 0);
        active_video = 1'b0;

        // Reset pulse mid-write aborts it and restores w0 priority
        w0_req = 1'b1; w0_addr = 15'd600; w0_data = 16'h0600;
        w1_req = 1'b1; w1_addr = 15'd700; w1_data = 16'h0700;
        step(); step(); step();
        #2 reset = 1'b0;
        #1 check_all_zero("reset_abort");
        model_reset();
        #2 reset = 1'b1;
        step(); check("after_reset_w0", w0_gnt, 1);
        w0_req = 1'b0; w1_req = 1'b0;
        step();

        // Randomized traffic with handshake-respecting writers
        av_left = 0;
        for (int n = 0; n < 1500; n++) begin
            if (av_left == 0) begin
                active_video = ~active_video;
                av_left = $urandom_range(1, 20);
            end
            av_left--;
            x = 10'($urandom_range(0, 639));
            y = 10'($urandom_range(0, 479));
            if (!w0_req || w0_gnt) begin
                w0_req  = ($urandom_range(0, 3) != 0);
                w0_addr = ($urandom_range(0, 199) == 0) ? 15'(19200 + $urandom_range(0, 99))
                                                        : 15'($urandom_range(0, 19199));
                w0_data = 16'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                w0_req = 1'b0;
            end
            if (!w1_req || w1_gnt) begin
                w1_req  = ($urandom_range(0, 3) != 0);
                w1_addr = 15'($urandom_range(0, 19199));
                w1_data = 16'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                w1_req = 1'b0;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_mem_arbiter.md
Name: vga_mem_arbiter

Overview:
- Shares one single-port pixel frame-buffer RAM between VGA scan-out and two pixel-writer clients (game/drawing logic).
- Sits between vga_controller (x, y, active_video) and the frame-buffer RAM, and drives the 5/6/5 RGB outputs.
- Scan-out owns the RAM during active video; writers are served round-robin during blanking with a req/gnt handshake.

Parameters:
- FB_W, 160, frame-buffer width in pixels (screen x >> SCALE_SHIFT)
- FB_H, 120, frame-buffer height in pixels (screen y >> SCALE_SHIFT)
- SCALE_SHIFT, 2, screen-to-buffer downscale (log2)
- ADDR_W, 15, RAM address width; must satisfy 2^ADDR_W >= FB_W*FB_H
- DATA_W, 16, pixel width, packed {r[4:0], g[5:0], b[4:0]}

Ports:
- clk_in  in  1  pixel clock (25 MHz domain, same as vga_controller)
- reset  in  1  asynchronous, active-low reset
- x  in  10  current scan x from vga_controller
- y  in  10  current scan y from vga_controller
- active_video  in  1  visible region flag
- w0_req / w1_req  in  1  writer write request
- w0_addr / w1_addr  in  ADDR_W  writer pixel address
- w0_data / w1_data  in  DATA_W  writer pixel data
- w0_gnt / w1_gnt  out  1  one-cycle grant pulse, write committed
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after mem_en with mem_we=0
- red  out  5  VGA red
- green  out  6  VGA green
- blue  out  5  VGA blue
- err_oob  out  1  sticky flag: a write with addr >= FB_W*FB_H was granted

Behaviour:
- Reset (reset=0, async): all outputs 0, state=BLANK_IDLE, round-robin pointer=w0. Registers take effect immediately, not at the next edge.
- All mem_*, gnt, RGB and err_oob outputs are registered.
- State machine, evaluated each clk_in edge:
  - SCAN when active_video=1.
  - BLANK_IDLE when active_video=0 and no req.
  - BLANK_WRITE when active_video=0 and any req.
- SCAN:
  - mem_en=1, mem_we=0.
  - mem_addr = (y>>SCALE_SHIFT)*FB_W + (x>>SCALE_SHIFT), computed with at least 2*ADDR_W-bit intermediate width and truncated to ADDR_W.
  - No grants are issued.
- Scan-out latency: 2 cycles from (x, y, active_video) sampled to RGB.
  - Cycle +1: address registered.
  - Cycle +2: {red, green, blue} = mem_rdata registered.
  - active_video is delayed by 2 cycles; when the delayed flag is 0, RGB = 0.
- BLANK_WRITE:
  - Exactly one writer is granted per cycle.
  - If both request, the writer pointed to by the RR pointer wins; the pointer then moves to the other writer.
  - A sole requester wins regardless of the pointer, and the pointer moves past it.
  - Winner's addr/data is sampled at edge N. At edge N+1: mem_en=1, mem_we=1, mem_addr/mem_wdata = sampled values, and wN_gnt=1 for exactly that cycle.
  - A writer holding req high is eligible again on the next cycle, giving back-to-back writes at 1 per cycle.
  - With both writers continuously requesting, grants alternate w0, w1, w0, ...
- Writer handshake:
  - Writer holds req/addr/data stable until it sees gnt, then may change or drop req in the gnt cycle.
  - Dropping req before gnt cancels the write; no RAM access occurs.
- active_video rising while requests are pending:
  - Any arbitration decided at that edge is void; pending writers wait (no gnt) until the next blanking interval.
  - Scan-out read is issued instead. Scan-out always wins.
- BLANK_IDLE: mem_en=0, mem_we=0; mem_addr/mem_wdata hold their last value.
- Out-of-range write (addr >= FB_W*FB_H):
  - Still granted (gnt pulses) but mem_we=0, mem_en=0 for that cycle.
  - err_oob set to 1 and held until reset.
- Reset asserted mid-write: the write is aborted, no gnt is issued, and the RR pointer returns to w0.

Test Plan:
- Reset: hold reset=0 with reqs active -> all outputs 0, no gnt. Release -> first blanking grant goes to w0 when both request.
- Scan-out: preload RAM addr 161 = 16'hF800; drive x=4, y=4, active_video=1 -> mem_addr=161 at +1; red=31, green=0, blue=0 at +2. active_video=0 -> RGB=0 two cycles later.
- Round-robin: active_video=0, w0_req=w1_req=1 held for 4 cycles -> gnt sequence w0, w1, w0, w1. mem_we=1 each cycle with matching addr/data.
- Blocking: w1_req=1 during active_video=1 for 10 cycles -> no w1_gnt, mem_we=0. First blanking cycle -> w1_gnt one cycle later, RAM written.
- Out-of-range: w0_addr=19200 during blanking -> w0_gnt pulses, mem_we=0, err_oob=1 and stays 1 until reset=0.
- Cancel and reset abort:
  - w0_req dropped for one cycle before its gnt -> no write.
  - reset=0 pulsed during BLANK_WRITE -> no gnt, next grant with both requesting goes to w0.
